// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache memory responder and the cache controller:
// FSM state encoding, default line geometry and the saturating stats increment.
package cache_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    localparam int unsigned DefaultWordWidth = 32;
    localparam int unsigned DefaultLineWords = 4;
    localparam int unsigned StatWidth        = 16;

    function automatic logic [StatWidth-1:0] sat_inc(input logic [StatWidth-1:0] v,
                                                     input logic                 en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

endpackage

// File: rtl/mem_line_ram.sv
// Synchronous single-port line store with a registered, resettable read port.
// Read and write have separate enables so a write never disturbs the read register.
module mem_line_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LINE_WIDTH-1:0] wdata_i,
    output logic [LINE_WIDTH-1:0] rdata_o
);

    logic [LINE_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [LINE_WIDTH-1:0] rdata_q;

    // Store contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Write-first: a simultaneous read returns the data being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= wr_en_i ? wdata_i : mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side responder: one line request at a time, completed after LATENCY busy cycles.
// Define CACHE_MEM_STATS_EN to add saturating request/ignored-request counters.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WORD_WIDTH = DefaultWordWidth,
    parameter int unsigned LINE_WORDS = DefaultLineWords,
    parameter int unsigned LATENCY    = 3,
    localparam int unsigned LINE_WIDTH = LINE_WORDS * WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_req_valid_i,
    input  logic                  mem_req_wen_i,
    input  logic [ADDR_WIDTH-1:0] mem_req_addr_i,
    input  logic [LINE_WIDTH-1:0] mem_req_data_i,
    output logic                  mem_res_valid_o,
    output logic [LINE_WIDTH-1:0] mem_res_data_o,
    output logic                  busy_o
`ifdef CACHE_MEM_STATS_EN
    ,
    output logic [StatWidth-1:0]  stat_reads_o,
    output logic [StatWidth-1:0]  stat_writes_o,
    output logic [StatWidth-1:0]  stat_ignored_o
`endif
);

    localparam logic [7:0] LatCnt = LATENCY[7:0];

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       accept;

    // A request arriving in the reset cycle is dropped, not half-accepted.
    assign accept = (state_q == S_IDLE) && mem_req_valid_i && !rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (LATENCY == 0) begin
                        state_d = S_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = S_BUSY;
                        cnt_d   = LatCnt;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Both outputs decode the state register directly, so they stay registered.
    assign mem_res_valid_o = (state_q == S_RESP);
    assign busy_o          = (state_q != S_IDLE);

    mem_line_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LINE_WIDTH (LINE_WIDTH)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (accept && mem_req_wen_i),
        .rd_en_i (accept && !mem_req_wen_i),
        .addr_i  (mem_req_addr_i),
        .wdata_i (mem_req_data_i),
        .rdata_o (mem_res_data_o)
    );

`ifdef CACHE_MEM_STATS_EN
    logic [StatWidth-1:0] reads_q, writes_q, ignored_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            reads_q   <= '0;
            writes_q  <= '0;
            ignored_q <= '0;
        end else begin
            reads_q   <= sat_inc(reads_q, accept && !mem_req_wen_i);
            writes_q  <= sat_inc(writes_q, accept && mem_req_wen_i);
            ignored_q <= sat_inc(ignored_q, mem_req_valid_i && (state_q != S_IDLE));
        end
    end

    assign stat_reads_o   = reads_q;
    assign stat_writes_o  = writes_q;
    assign stat_ignored_o = ignored_q;
`endif

endmodule
